// File: rtl/fb_write_scheduler_if.sv
// Frame-buffer scheduler bus bundle.
// Groups the scan-out request, the single-pixel write channel, the fill
// control and the BRAM port. "master" is the client/requester side,
// "slave" is the scheduler itself.
interface fb_write_scheduler_if #(
    parameter int BUFFER_ADDR_BITS = 17,
    parameter int COLOR_BITS       = 8
);
    // VGA scan-out read request
    logic                        scan_active;
    logic [31:0]                 scan_addr;

    // single-pixel write request channel
    logic                        wr_valid;
    logic                        wr_ready;
    logic [BUFFER_ADDR_BITS-1:0] wr_addr;
    logic [COLOR_BITS-1:0]       wr_color;

    // whole-buffer fill control
    logic                        fill_start;
    logic [COLOR_BITS-1:0]       fill_color;
    logic                        fill_busy;
    logic                        fill_done;

    // BRAM port
    logic [31:0]                 buffer_addr;
    logic [31:0]                 buffer_din;
    logic [3:0]                  buffer_we;
    logic                        buffer_en;
    logic                        buffer_rst;

    modport master (
        output scan_active, scan_addr,
        output wr_valid, wr_addr, wr_color,
        output fill_start, fill_color,
        input  wr_ready, fill_busy, fill_done,
        input  buffer_addr, buffer_din, buffer_we, buffer_en, buffer_rst
    );

    modport slave (
        input  scan_active, scan_addr,
        input  wr_valid, wr_addr, wr_color,
        input  fill_start, fill_color,
        output wr_ready, fill_busy, fill_done,
        output buffer_addr, buffer_din, buffer_we, buffer_en, buffer_rst
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write scheduler.
// Arbitrates a single BRAM port (32-bit words, one pixel per byte lane)
// between VGA scan-out reads, single-pixel writes and a whole-buffer fill.
// Scan-out always wins the port; writes and fill steps only happen in
// cycles where scan-out leaves the port free.
module fb_write_scheduler #(
    parameter int BUFFER_ADDR_BITS = 17,
    parameter int NUM_PIXELS       = 120000,
    parameter int COLOR_BITS       = 8
) (
    input  logic                vga_clk,
    input  logic                resetn,
    fb_write_scheduler_if.slave bus
);

    // fill_cnt counts 32-bit words, so it is two bits narrower than a byte address
    localparam int CNT_BITS      = BUFFER_ADDR_BITS - 2;
    localparam int LAST_WORD_INT = (NUM_PIXELS - 1) >> 2;
    localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(LAST_WORD_INT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Widen a pixel colour to one byte lane and replicate it across the word.
    function automatic logic [31:0] replicate_color(input logic [COLOR_BITS-1:0] c);
        logic [7:0] lane;
        lane = 8'(c);
        return {4{lane}};
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [0:0]                  state;
    logic                        pend_valid;
    logic [BUFFER_ADDR_BITS-1:0] pend_addr;
    logic [COLOR_BITS-1:0]       pend_color;
    logic                        fill_req;
    logic [COLOR_BITS-1:0]       fill_col_q;
    logic [CNT_BITS-1:0]         fill_cnt;
    logic                        fill_done_q;

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    logic in_idle;
    logic in_fill;
    logic commit;      // pending pixel owns the port this cycle
    logic fill_step;   // fill writes one word this cycle
    logic last_step;   // ... and it is the final word
    logic handshake;   // write request accepted at the next edge
    logic fill_latch;  // fill_start captured at the next edge
    logic fill_enter;  // IDLE -> FILL at the next edge

    assign in_idle    = (state == ST_IDLE);
    assign in_fill    = (state == ST_FILL);
    assign commit     = in_idle & pend_valid & ~bus.scan_active;
    assign fill_step  = in_fill & ~bus.scan_active;
    assign last_step  = fill_step & (fill_cnt == LAST_WORD);

    // A slot opens when the holding register is empty or drains this cycle;
    // new writes are refused once a fill has been requested.
    assign bus.wr_ready = resetn & in_idle & ~fill_req & (~pend_valid | commit);

    assign handshake  = bus.wr_valid & bus.wr_ready;
    assign fill_latch = in_idle & ~fill_req & bus.fill_start;
    // The pending write must drain before the fill takes over the port.
    assign fill_enter = in_idle & fill_req & ~pend_valid;

    // ---------------------------------------------------------------
    // Status outputs
    // ---------------------------------------------------------------
    assign bus.fill_busy  = fill_req | in_fill;
    assign bus.fill_done  = fill_done_q;
    assign bus.buffer_en  = 1'b1;
    assign bus.buffer_rst = 1'b0;

    // Drive the BRAM port: scan-out first, then fill, then a pending pixel.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        bus.buffer_addr = '0;
        bus.buffer_we   = '0;
        bus.buffer_din  = '0;
        if (bus.scan_active) begin
            bus.buffer_addr = bus.scan_addr;
        end else if (in_fill) begin
            bus.buffer_addr = 32'({fill_cnt, 2'b00});
            bus.buffer_we   = 4'hF;
            bus.buffer_din  = replicate_color(fill_col_q);
        end else if (commit) begin
            bus.buffer_addr = 32'(pend_addr);
            bus.buffer_we   = 4'b0001 << pend_addr[1:0];
            bus.buffer_din  = replicate_color(pend_color);
        end
    end

    // Hold one pending pixel; a same-cycle handshake refills the slot as it drains.
    always_ff @(posedge vga_clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_color <= '0;
        end else if (handshake) begin
            pend_valid <= 1'b1;
            pend_addr  <= bus.wr_addr;
            pend_color <= bus.wr_color;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end
    end

    // Capture a fill request and its colour; extra requests are dropped until it starts.
    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            fill_req   <= 1'b0;
            fill_col_q <= '0;
        end else if (fill_enter) begin
            fill_req   <= 1'b0;
        end else if (fill_latch) begin
            fill_req   <= 1'b1;
            fill_col_q <= bus.fill_color;
        end
    end

    // IDLE/FILL sequencing and the word counter, which stalls while scan-out owns the port.
    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            fill_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fill_enter) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (last_step) begin
                        state    <= ST_IDLE;
                        fill_cnt <= '0;
                    end else if (fill_step) begin
                        fill_cnt <= fill_cnt + CNT_BITS'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

    // One-cycle completion pulse in the cycle after the final word is written.
    always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= last_step;
        end
    end

endmodule
